// File: rtl/snn_map_pkg.sv
// snn_map_pkg: accelerator address-map fields, region encodings, sequencer states and address packing
package snn_map_pkg;
  localparam int CORE_BIT = 16;
  localparam int REGION_LSB = 17;
  localparam int CALC_LSB = 20;
  localparam logic [1:0] REG_SPIKE_IN = 2'b00;
  localparam logic [1:0] REG_PARAM = 2'b01;
  localparam logic [1:0] REG_SPIKE_OUT = 2'b10;
  localparam logic [1:0] REG_RUN = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_RUN, S_FIN} state_t;
  function automatic logic [31:0] pack_addr(input logic core, input logic [1:0] region,
                                            input logic [1:0] calc, input logic [15:0] offset);
    logic [31:0] a;
    a = {16'd0, offset};
    a[CORE_BIT] = core;
    a[REGION_LSB +: 2] = region;
    a[CALC_LSB +: 2] = calc;
    return a;
  endfunction
endpackage

// File: rtl/snn_rd_buf.sv
// snn_rd_buf: single-entry read buffer, data held stable while valid and not ready
module snn_rd_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] dout
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid <= 1'b0;
      dout <= '0;
    end else begin
      valid <= load || (valid && !ready);
      if (load) dout <= din;
    end
  end
endmodule

// File: rtl/snn_host_sequencer.sv
// snn_host_sequencer: turns host block commands into single-beat accelerator bus transactions
module snn_host_sequencer
  import snn_map_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_core_i,
  input  logic [1:0]        cmd_op_i,
  input  logic [15:0]       cmd_base_i,
  input  logic [7:0]        cmd_len_i,
  input  logic [1:0]        cmd_calc_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              busy_o,
  output logic              done_o
);
  state_t state_q, state_d;
  logic core_q;
  logic [1:0] op_q, calc_q;
  logic [15:0] base_q;
  logic [7:0] len_q, idx_q;
  logic cmd_fire, wr_fire, gnt, last, issue, rd_load;
  assign cmd_ready_o = rst_ni && state_q == S_IDLE;
  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_FIN && !rd_valid_o;
  assign wr_ready_o = state_q == S_WR && !bus_req_o;
  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign wr_fire = wr_valid_i && wr_ready_o;
  assign gnt = bus_req_o && bus_gnt_i;
  assign last = idx_q == len_q - 8'd1;
  assign rd_load = state_q == S_RWAIT && bus_rvalid_i;
  // a read is only issued once its response is guaranteed a free buffer slot
  assign issue = wr_fire || (!bus_req_o && (state_q == S_RUN ||
                 (state_q == S_RD && (!rd_valid_o || rd_ready_i))));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = cmd_op_i == REG_SPIKE_OUT ? S_RD :
                                       cmd_op_i == REG_RUN ? S_RUN : S_WR;
      S_WR:    if (gnt && last) state_d = S_FIN;
      S_RD:    if (gnt) state_d = S_RWAIT;
      S_RWAIT: if (bus_rvalid_i) state_d = last ? S_FIN : S_RD;
      S_RUN:   if (gnt) state_d = S_FIN;
      S_FIN:   if (!rd_valid_o) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_q <= 1'b0;
      op_q <= 2'b00;
      calc_q <= 2'b00;
      base_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
    end else begin
      if (cmd_fire) begin
        core_q <= cmd_core_i;
        op_q <= cmd_op_i;
        calc_q <= cmd_calc_i;
        base_q <= cmd_base_i;
        len_q <= cmd_len_i;
        idx_q <= '0;
      end
      if ((state_q == S_WR && gnt) || rd_load) idx_q <= idx_q + 8'd1;
      if (gnt) bus_req_o <= 1'b0;
      if (issue) begin
        bus_req_o <= 1'b1;
        bus_we_o <= state_q != S_RD;
        bus_addr_o <= ADDR_W'(pack_addr(core_q, op_q, calc_q, base_q + {8'd0, idx_q}));
        bus_wdata_o <= state_q == S_WR ? wr_data_i : '0;
      end
    end
  end
  snn_rd_buf #(.DATA_W(DATA_W)) u_rd_buf (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (rd_load),
    .din   (bus_rdata_i),
    .valid (rd_valid_o),
    .ready (rd_ready_i),
    .dout  (rd_data_o)
  );
endmodule

// File: tb/tb_snn_host_sequencer.sv
// tb_snn_host_sequencer: command table driven through bus/stream models with beat and read-data scoreboards
`timescale 1ns/1ps
module tb_snn_host_sequencer;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} beat_t;
  typedef struct {
    logic core; logic [1:0] op; logic [15:0] base; logic [7:0] len; logic [1:0] calc;
    logic [31:0] first; bit rnd; int stall; int busy;
  } vec_t;
  logic clk = 0, rst_ni = 0;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_core_i = 0;
  logic [1:0] cmd_op_i = 0, cmd_calc_i = 0;
  logic [15:0] cmd_base_i = 0;
  logic [7:0] cmd_len_i = 0;
  logic wr_valid_i = 0, wr_ready_o, rd_valid_o, rd_ready_i = 0;
  logic [31:0] wr_data_i = 0, rd_data_o;
  logic bus_req_o, bus_gnt_i = 0, bus_we_o, bus_rvalid_i = 0, busy_o, done_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i = 0;
  int tests = 0, fails = 0, cyc = 0, ready_at = 0, done_cnt = 0, busy_cnt = 0;
  bit gnt_rand = 0, stray = 0;
  beat_t exp_bus[$];
  logic [31:0] exp_rd[$], wr_q[$], granted[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snn_host_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_core_i(cmd_core_i),
    .cmd_op_i(cmd_op_i), .cmd_base_i(cmd_base_i), .cmd_len_i(cmd_len_i), .cmd_calc_i(cmd_calc_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] map_addr(input logic core, input logic [1:0] op,
                                           input logic [1:0] calc, input logic [15:0] off);
    return {10'd0, calc, 1'b0, op, core, off};
  endfunction

  function automatic int beats_of(input vec_t v);
    return v.op == 2'b11 ? 1 : (v.len == 0 ? 256 : int'(v.len));
  endfunction

  // write stream source
  initial forever begin
    @(negedge clk);
    wr_valid_i = wr_q.size() != 0;
    wr_data_i = wr_valid_i ? wr_q[0] : '0;
    #3;
    if (!rst_ni) wr_q.delete();
    else if (wr_valid_i && wr_ready_o) void'(wr_q.pop_front());
  end

  // bus slave: grant model, read responder two cycles after grant, beat scoreboard
  initial begin
    logic [65:0] pend;
    bit pend_v;
    int rv_cnt;
    beat_t e;
    pend_v = 0;
    rv_cnt = 0;
    forever begin
      @(negedge clk);
      bus_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus_rvalid_i = stray;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i = $urandom;
          exp_rd.push_back(bus_rdata_i);
        end
      end
      #3;
      if (!rst_ni) begin
        pend_v = 0;
        rv_cnt = 0;
        exp_bus.delete();
      end else begin
        if (pend_v) check("bus_hold", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}, pend);
        if (bus_req_o && !bus_we_o) check("rd_req_buf_empty", rd_valid_o, 0);
        pend_v = bus_req_o && !bus_gnt_i;
        pend = {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o};
        if (bus_req_o && bus_gnt_i) begin
          granted.push_back(bus_addr_o);
          if (exp_bus.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL bus_extra_beat: got addr %0h expected no beat", bus_addr_o);
          end else begin
            e = exp_bus.pop_front();
            check("bus_addr", bus_addr_o, e.addr);
            check("bus_we", bus_we_o, e.we);
            check("bus_wdata", bus_wdata_o, e.wdata);
          end
          if (!bus_we_o) rv_cnt = 2;
        end
      end
    end
  end

  // read stream sink with stall window, read scoreboard, done/busy counters
  initial begin
    logic [31:0] hold_d;
    bit hold_v;
    hold_v = 0;
    hold_d = 0;
    forever begin
      @(negedge clk);
      rd_ready_i = cyc >= ready_at;
      #3;
      if (hold_v && rd_valid_o) check("rd_hold", rd_data_o, hold_d);
      hold_v = rd_valid_o && !rd_ready_i;
      hold_d = rd_data_o;
      if (rd_valid_o && rd_ready_i) begin
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_extra_word: got %0h expected no word", rd_data_o);
        end else check("rd_data", rd_data_o, exp_rd.pop_front());
      end
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  task automatic start_cmd(input vec_t v);
    int n, t;
    logic [31:0] w;
    n = beats_of(v);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_bus.push_back('{map_addr(v.core, v.op, v.calc, v.base + 16'(i)), v.op != 2'b10,
                          v.op[1] ? 32'd0 : w});
      if (!v.op[1]) wr_q.push_back(w);
    end
    gnt_rand = v.rnd;
    ready_at = cyc + v.stall;
    @(negedge clk);
    cmd_valid_i = 1;
    cmd_core_i = v.core;
    cmd_op_i = v.op;
    cmd_base_i = v.base;
    cmd_len_i = v.len;
    cmd_calc_i = v.calc;
    t = 0;
    while (!cmd_ready_o && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 0;
  endtask

  task automatic run_cmd(input vec_t v);
    int d0, b0, g0, t;
    d0 = done_cnt;
    b0 = busy_cnt;
    g0 = granted.size();
    start_cmd(v);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    #4;
    check("done_once", done_cnt - d0, 1);
    check("beat_count", granted.size() - g0, beats_of(v));
    check("first_addr", granted.size() > g0 ? granted[g0] : 32'hx, v.first);
    check("bus_sb_drained", exp_bus.size(), 0);
    check("rd_sb_drained", exp_rd.size(), 0);
    if (v.busy != 0) check("busy_cycles", busy_cnt - b0, v.busy);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    int t, g0;
    vecs[0] = '{1'b1, 2'b01, 16'h0010, 8'd3, 2'b00, 32'h0003_0010, 1'b0, 0, 7};
    vecs[1] = '{1'b0, 2'b10, 16'h0000, 8'd2, 2'b00, 32'h0004_0000, 1'b0, 9, 0};
    vecs[2] = '{1'b1, 2'b11, 16'h0000, 8'd5, 2'b11, 32'h0037_0000, 1'b0, 0, 3};
    vecs[3] = '{1'b0, 2'b00, 16'hFFFF, 8'd2, 2'b01, 32'h0010_FFFF, 1'b0, 0, 5};
    vecs[4] = '{1'b1, 2'b00, 16'h0100, 8'd0, 2'b10, 32'h0021_0100, 1'b0, 0, 513};
    vecs[5] = '{1'b1, 2'b10, 16'h0200, 8'd4, 2'b01, 32'h0015_0200, 1'b1, 3, 0};
    vecs[6] = '{1'b0, 2'b01, 16'h1234, 8'd5, 2'b00, 32'h0002_1234, 1'b1, 0, 0};
    #3;
    check("rst_ctrl", {bus_req_o, bus_we_o, wr_ready_o, rd_valid_o, busy_o, done_o}, 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_wdata", bus_wdata_o, 0);
    check("rst_rdata", rd_data_o, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1;
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1);
    foreach (vecs[i]) run_cmd(vecs[i]);
    // stray read response while idle must not reach the read stream
    stray = 1;
    @(negedge clk);
    #1 stray = 0;
    @(negedge clk);
    #3;
    check("stray_rvalid", {rd_valid_o, busy_o}, 0);
    // asynchronous reset in the middle of a stalled write command
    v = '{1'b0, 2'b01, 16'h0300, 8'd8, 2'b00, 32'h0002_0300, 1'b1, 0, 0};
    g0 = granted.size();
    start_cmd(v);
    t = 0;
    while (granted.size() < g0 + 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pre_reset_beats", granted.size() >= g0 + 3, 1);
    check("pre_reset_first", granted.size() > g0 ? granted[g0] : 32'hx, 32'h0002_0300);
    @(posedge clk);
    #2 rst_ni = 0;
    #1;
    check("async_rst_ctrl", {bus_req_o, bus_we_o, wr_ready_o, rd_valid_o, busy_o, done_o}, 0);
    check("async_rst_addr", bus_addr_o, 0);
    check("async_rst_wdata", bus_wdata_o, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1;
    #1;
    check("post_rst_cmd_ready", cmd_ready_o, 1);
    run_cmd('{1'b0, 2'b00, 16'h0040, 8'd2, 2'b00, 32'h0000_0040, 1'b1, 0, 0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
